lamp_fader: RTL and testbench
=============================

Name: lamp_fader

Overview:
- Downstream of the lighting controller; consumes the lamp request (saida) and drives the physical lamp.
- Replaces hard on/off switching with a PWM output and timed linear soft-start/soft-stop ramps.
- Provides status flags (fading, at_full) for indicator or debug use.

Parameters:
- PWM_BITS, 8: width of the brightness level and PWM counter; MAX = 2^PWM_BITS-1.
- TICK_DIV, 50000: clk cycles per 1 ms tick.
- FADE_STEP_MS, 4: ms between successive 1-LSB level steps (default full ramp = 255*4 = 1020 ms).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- lamp_req  input  1  lamp request from the controller (saida); 1 = lamp on.
- instant  input  1  1 = skip ramps; level jumps to target on the next edge.
- pwm_out  output  1  lamp drive.
- level  output  PWM_BITS  current brightness.
- fading  output  1  high in RAMP_UP or RAMP_DOWN.
- at_full  output  1  high in ON (level == MAX).

Behaviour:
- Reset (rst=0, asynchronous): state OFF, level=0, all counters 0, pwm_out=0, fading=0, at_full=0.
- Tick generation:
  - ms prescaler counts 0..TICK_DIV-1 and pulses ms_tick at TICK_DIV-1.
  - step counter counts ms_ticks 0..FADE_STEP_MS-1; step_tick is asserted on the ms_tick where it equals FADE_STEP_MS-1.
  - Both counters clear on every state change, so the first step comes exactly FADE_STEP_MS*TICK_DIV clocks after ramp entry.
- FSM (registered) — OFF, RAMP_UP, ON, RAMP_DOWN:
  - OFF: lamp_req=1 → RAMP_UP (instant=0) or ON with level=MAX (instant=1).
  - RAMP_UP:
    - each step_tick increments level by 1; the step that makes level==MAX also moves to ON on the same edge.
    - lamp_req=0 → RAMP_DOWN from the current level, no jump.
  - ON: level held at MAX; lamp_req=0 → RAMP_DOWN, or OFF with level=0 if instant=1.
  - RAMP_DOWN:
    - each step_tick decrements level by 1; the step that makes level==0 also moves to OFF.
    - lamp_req=1 → RAMP_UP from the current level.
  - instant=1 in either ramp state → next edge jumps to the target: ON/MAX if lamp_req=1, else OFF/0.
- Level arithmetic never wraps: it saturates at 0 and MAX by construction.
- PWM:
  - Free-running PWM_BITS counter, incremented every clk, wraps MAX→0.
  - pwm_out registered: 1 when level==MAX; else (pwm_cnt < level).
  - level=0 → constant 0; level=MAX → constant 1.
  - Latency from level change to pwm_out: 1 clk.
- Outputs:
  - fading and at_full are decoded from the state register (no extra latency).
  - lamp_req toggling within one cycle is handled purely by the state rules above; no glitch on level.
- lamp_req is already synchronous to clk; no internal synchronizer.
- Reset mid-ramp: immediate return to reset values; no resume.

Optional Feature:
- Macro: LAMP_FADER_GAMMA_EN.
- Defined:
  - PWM compare uses duty = (level*level) >> PWM_BITS instead of level, for a perceptually linear fade.
  - level==MAX still forces constant 1; level==0 gives constant 0.
  - The squaring is a combinational multiply, registered before the compare; pwm_out latency becomes 2 clk.
  - The level output stays linear.
- Undefined: duty = level; latency 1 clk; no multiplier inferred.

Test Plan (PWM_BITS=4, TICK_DIV=1, FADE_STEP_MS=2, MAX=15 unless noted):
- Reset, then lamp_req=1 held:
  - fading=1 one clk after the request is sampled;
  - level steps by 1 every 2 clk;
  - level=15, at_full=1, fading=0 exactly 30 clk after RAMP_UP entry.
- From ON, lamp_req=0 → level reaches 0 and state OFF after 30 clk; pwm_out=0 afterwards over 32 clk.
- Reversal: ramp up until level=6, then drop lamp_req → level goes 6,5,4… without jumping.
  - Reassert at level=3 → climbs back from 3.
- instant=1 with lamp_req rising in OFF → next edge level=15, at_full=1, fading=0.
  - Then lamp_req=0 → next edge level=0.
- PWM duty:
  - freeze at level=5 (hold the ramp with TICK_DIV large) → pwm_out high for 5 of every 16 clk;
  - level=15 → constant 1.
- Assert rst low asynchronously mid RAMP_UP (level=9), between clock edges → all outputs 0 before the next edge; after release, state OFF.

Source files
------------

// File: rtl/lamp_fader.sv
// rtl/lamp_fader.sv - PWM lamp driver with timed linear soft-start/soft-stop ramps
// Optional LAMP_FADER_GAMMA_EN: squared-level PWM duty (pwm_out latency 2 clk).
module lamp_fader #(
    parameter int PWM_BITS     = 8,
    parameter int TICK_DIV     = 50000,
    parameter int FADE_STEP_MS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lamp_req,
    input  logic                instant,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] level,
    output logic                fading,
    output logic                at_full
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STP_W = (FADE_STEP_MS > 1) ? $clog2(FADE_STEP_MS) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [STP_W-1:0]    STP_LAST = STP_W'(FADE_STEP_MS - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

    typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

    state_t              state;
    logic [PRE_W-1:0]    pre_cnt;
    logic [STP_W-1:0]    step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                ms_tick;
    logic                step_tick;

    assign ms_tick   = (pre_cnt == PRE_LAST);
    assign step_tick = ms_tick && (step_cnt == STP_LAST);
    assign fading    = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign at_full   = (state == ON);

    // Tick counters free-run; every state change clears them so a ramp's first step is a full period away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= OFF;
            level    <= '0;
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            if (ms_tick) begin
                pre_cnt  <= '0;
                step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            end else begin
                pre_cnt  <= pre_cnt + 1'b1;
            end
            case (state)
                OFF: begin
                    if (lamp_req) begin
                        pre_cnt  <= '0;
                        step_cnt <= '0;
                        if (instant) begin
                            state <= ON;
                            level <= MAX;
                        end else begin
                            state <= RAMP_UP;
                        end
                    end
                end
                ON: begin
                    if (!lamp_req) begin
                        pre_cnt  <= '0;
                        step_cnt <= '0;
                        if (instant) begin
                            state <= OFF;
                            level <= '0;
                        end else begin
                            state <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_UP: begin
                    if (instant || !lamp_req || (step_tick && level >= MAX - 1'b1)) begin
                        pre_cnt  <= '0;
                        step_cnt <= '0;
                    end
                    if (instant) begin
                        state <= lamp_req ? ON : OFF;
                        level <= lamp_req ? MAX : '0;
                    end else if (!lamp_req) begin
                        state <= RAMP_DOWN;
                    end else if (step_tick) begin
                        if (level >= MAX - 1'b1) begin
                            state <= ON;
                            level <= MAX;
                        end else begin
                            level <= level + 1'b1;
                        end
                    end
                end
                default: begin
                    if (instant || lamp_req || (step_tick && level <= ONE)) begin
                        pre_cnt  <= '0;
                        step_cnt <= '0;
                    end
                    if (instant) begin
                        state <= lamp_req ? ON : OFF;
                        level <= lamp_req ? MAX : '0;
                    end else if (lamp_req) begin
                        state <= RAMP_UP;
                    end else if (step_tick) begin
                        if (level <= ONE) begin
                            state <= OFF;
                            level <= '0;
                        end else begin
                            level <= level - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LAMP_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_w;
    logic [PWM_BITS-1:0]   duty_q;
    logic                  full_q;

    assign level_w = {{PWM_BITS{1'b0}}, level};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
            full_q  <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            duty_q  <= PWM_BITS'((level_w * level_w) >> PWM_BITS);
            full_q  <= (level == MAX);
            pwm_out <= full_q || (pwm_cnt < duty_q);
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (level == MAX) || (pwm_cnt < level);
        end
    end
`endif
endmodule

// File: tb/tb_lamp_fader.sv
// tb/tb_lamp_fader.sv - self-checking bench for lamp_fader against a behavioural lamp model
module tb_lamp_fader;
    localparam int W = 4, TD = 1, FS = 2, MAXL = 15, STEP_CLKS = TD * FS;
    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DOWN = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         lamp_req = 1'b0;
    logic         instant = 1'b0;
    logic         pwm_out;
    logic [W-1:0] level;
    logic         fading;
    logic         at_full;

    lamp_fader #(.PWM_BITS(W), .TICK_DIV(TD), .FADE_STEP_MS(FS)) dut (
        .clk(clk), .rst(rst), .lamp_req(lamp_req), .instant(instant),
        .pwm_out(pwm_out), .level(level), .fading(fading), .at_full(at_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_mode, m_level, m_elapsed, m_pcnt, m_pwm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_level = 0; m_elapsed = 0; m_pcnt = 0; m_pwm = 0;
    endtask

    // One clock of the lamp: PWM uses the brightness before the edge; ramps step every STEP_CLKS clocks in a state.
    task automatic model_step(input bit req, input bit inst);
        int nm, nl;
        bit step;
        nm = m_mode; nl = m_level;
        m_pwm = (m_level == MAXL || m_pcnt < m_level) ? 1 : 0;
        m_pcnt = (m_pcnt + 1) % (MAXL + 1);
        m_elapsed++;
        step = (m_elapsed % STEP_CLKS) == 0;
        if (m_mode == M_OFF) begin
            if (req) begin nm = inst ? M_ON : M_UP; if (inst) nl = MAXL; end
        end else if (m_mode == M_ON) begin
            if (!req) begin nm = inst ? M_OFF : M_DOWN; if (inst) nl = 0; end
        end else if (inst) begin
            nm = req ? M_ON : M_OFF; nl = req ? MAXL : 0;
        end else if (m_mode == M_UP) begin
            if (!req) nm = M_DOWN;
            else if (step) begin
                nl = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
                if (nl == MAXL) nm = M_ON;
            end
        end else begin
            if (req) nm = M_UP;
            else if (step) begin
                nl = (m_level - 1 < 0) ? 0 : m_level - 1;
                if (nl == 0) nm = M_OFF;
            end
        end
        if (nm != m_mode) m_elapsed = 0;
        m_mode = nm; m_level = nl;
    endtask

    task automatic cycle(input bit req, input bit inst);
        lamp_req = req; instant = inst;
        @(posedge clk);
        model_step(req, inst);
        #1;
        check("level", level, m_level);
        check("fading", fading, (m_mode == M_UP || m_mode == M_DOWN));
        check("at_full", at_full, (m_mode == M_ON));
        check("pwm_out", pwm_out, m_pwm);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_pwm"}, pwm_out, 0);
        check({tag, "_fading"}, fading, 0);
        check({tag, "_at_full"}, at_full, 0);
    endtask

    initial begin
        int n, cnt, prev;
        model_reset();
        #7;
        check_zero("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // Full soft-start: 30 clocks from ramp entry to full
        cycle(1, 0);
        check("fading_after_req", fading, 1);
        n = 0;
        while (!at_full && n < 100) begin cycle(1, 0); n++; end
        check("ramp_up_clks", n, 30);
        check("ramp_up_level", level, MAXL);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin cycle(1, 0); cnt += pwm_out; end
        check("pwm_full_duty", cnt, 16);

        // Full soft-stop, then dark
        cycle(0, 0);
        n = 0;
        while (m_mode != M_OFF && n < 100) begin cycle(0, 0); n++; end
        check("ramp_down_clks", n, 30);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin cycle(0, 0); cnt += pwm_out; end
        check("pwm_off_duty", cnt, 0);

        // Reversal mid-ramp
        n = 0;
        while (m_level != 6 && n < 100) begin cycle(1, 0); n++; end
        cycle(0, 0);
        check("rev_nojump", level, 6);
        prev = 6; n = 0;
        while (m_level != 3 && n < 100) begin
            cycle(0, 0);
            check("rev_step", (prev - int'(level) >= 0 && prev - int'(level) <= 1), 1);
            prev = int'(level); n++;
        end
        cycle(1, 0);
        check("rev_hold3", level, 3);
        n = 0;
        while (m_level == 3 && n < 100) begin cycle(1, 0); n++; end
        check("rev_climb4", level, 4);

        // Instant jumps
        cycle(0, 1);
        cycle(0, 0);
        cycle(1, 1);
        check("inst_on_level", level, MAXL);
        check("inst_on_full", at_full, 1);
        check("inst_on_fading", fading, 0);
        cycle(0, 1);
        check("inst_off_level", level, 0);

        // Hold level 5 by toggling the request each clock, then measure duty
        n = 0;
        while (m_level != 5 && n < 100) begin cycle(1, 0); n++; end
        for (int i = 0; i < 8; i++) cycle(i % 2 == 1, 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin cycle(i % 2 == 1, 0); cnt += pwm_out; end
        check("pwm_duty5", cnt, 5);
        check("duty_level", level, 5);

        // Asynchronous reset between edges mid-ramp
        n = 0;
        while (m_level != 9 && n < 100) begin cycle(1, 0); n++; end
        check("pre_reset_level", level, 9);
        #2 rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        cycle(0, 0);

        // Randomized request/instant traffic against the model
        begin
            bit req = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(19) == 0) req = ~req;
                cycle(req, $urandom_range(15) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
